// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter and its ALU.
package alu_arb_pkg;

   localparam int XLEN = 32;

   typedef logic [2:0] alu_ctrl_t;

   localparam alu_ctrl_t ALU_ADD = 3'b000;
   localparam alu_ctrl_t ALU_SUB = 3'b001;
   localparam alu_ctrl_t ALU_AND = 3'b010;
   localparam alu_ctrl_t ALU_OR  = 3'b011;
   localparam alu_ctrl_t ALU_SLT = 3'b101;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_idx_t;

   typedef struct packed {
      logic [XLEN-1:0] srca;
      logic [XLEN-1:0] srcb;
      alu_ctrl_t       ctrl;
      req_idx_t        owner;
   } stage_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational single-cycle ALU; SLT compares operands as signed values.
module alu
   import alu_arb_pkg::*;
(
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  alu_ctrl_t       ALUControl,
   output logic [XLEN-1:0] ALUResult,
   output logic            Zero
);

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves ALUResult unassigned (no latch).
      ALUResult = '0;
      case (ALUControl)
         ALU_ADD: ALUResult = SrcA + SrcB;
         ALU_SUB: ALUResult = SrcA - SrcB;
         ALU_AND: ALUResult = SrcA & SrcB;
         ALU_OR:  ALUResult = SrcA | SrcB;
         ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         default: ALUResult = '0;
      endcase
   end

   assign Zero = (ALUResult == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: accept -> stage -> response register.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [XLEN-1:0]  req0_srca,
   input  logic [XLEN-1:0]  req0_srcb,
   input  alu_ctrl_t        req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [XLEN-1:0]  req1_srca,
   input  logic [XLEN-1:0]  req1_srcb,
   input  alu_ctrl_t        req1_ctrl,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [XLEN-1:0]  rsp0_result,
   output logic             rsp0_zero,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [XLEN-1:0]  rsp1_result,
   output logic             rsp1_zero,
   output logic [CNT_W-1:0] op_count
);

   logic [1:0]      req_valid;
   logic [1:0]      rsp_ready;
   logic [XLEN-1:0] req_srca [2];
   logic [XLEN-1:0] req_srcb [2];
   alu_ctrl_t       req_ctrl [2];

   assign req_valid   = {req1_valid, req0_valid};
   assign rsp_ready   = {rsp1_ready, rsp0_ready};
   assign req_srca[0] = req0_srca;
   assign req_srca[1] = req1_srca;
   assign req_srcb[0] = req0_srcb;
   assign req_srcb[1] = req1_srcb;
   assign req_ctrl[0] = req0_ctrl;
   assign req_ctrl[1] = req1_ctrl;

   logic            stage_valid_q, stage_valid_d;
   stage_t          stage_q, stage_d;
   req_idx_t        rr_ptr_q, rr_ptr_d;
   logic [1:0]      rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0] rsp_result_q [2];
   logic [XLEN-1:0] rsp_result_d [2];
   logic [1:0]      rsp_zero_q, rsp_zero_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic [1:0]      pend, elig, grant;
   req_idx_t        grant_idx;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;

   alu u_alu (
      .SrcA       (stage_q.srca),
      .SrcB       (stage_q.srcb),
      .ALUControl (stage_q.ctrl),
      .ALUResult  (alu_result),
      .Zero       (alu_zero)
   );

   // A requester with an op in the stage or an unconsumed result is not eligible again.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         pend[n] = (stage_valid_q && stage_q.owner == req_idx_t'(n))
                 || (rsp_valid_q[n] && !rsp_ready[n]);
         elig[n] = req_valid[n] && !pend[n];
      end
      grant = 2'b00;
      if (!reset) begin
         if (elig == 2'b11) grant = (rr_ptr_q == REQ0) ? 2'b01 : 2'b10;
         else               grant = elig;
      end
      grant_idx = grant[1] ? REQ1 : REQ0;
   end

   always_comb begin
      stage_valid_d = |grant;
      stage_d       = stage_q;
      rr_ptr_d      = rr_ptr_q;
      if (|grant) begin
         stage_d  = '{srca: req_srca[grant_idx], srcb: req_srcb[grant_idx],
                      ctrl: req_ctrl[grant_idx], owner: grant_idx};
         rr_ptr_d = (grant_idx == REQ0) ? REQ1 : REQ0;
      end
      // A load from the stage wins over a same-edge consume.
      for (int n = 0; n < 2; n++) begin
         rsp_valid_d[n]  = rsp_valid_q[n] && !rsp_ready[n];
         rsp_result_d[n] = rsp_result_q[n];
         rsp_zero_d[n]   = rsp_zero_q[n];
         if (stage_valid_q && stage_q.owner == req_idx_t'(n)) begin
            rsp_valid_d[n]  = 1'b1;
            rsp_result_d[n] = alu_result;
            rsp_zero_d[n]   = alu_zero;
         end
      end
      op_count_d = op_count_q + CNT_W'(stage_valid_q);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (reset) begin
         stage_valid_q <= 1'b0;
         rr_ptr_q      <= REQ0;
         rsp_valid_q   <= '0;
         op_count_q    <= '0;
      end else begin
         stage_valid_q <= stage_valid_d;
         rr_ptr_q      <= rr_ptr_d;
         rsp_valid_q   <= rsp_valid_d;
         op_count_q    <= op_count_d;
      end
   end

   // NOTE: data registers are deliberately not reset; they are only observed when qualified by a valid.
   always_ff @(posedge clk) begin
      stage_q      <= stage_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
   end

   assign req0_ready  = grant[0];
   assign req1_ready  = grant[1];
   assign rsp0_valid  = rsp_valid_q[0];
   assign rsp1_valid  = rsp_valid_q[1];
   assign rsp0_result = rsp_result_q[0];
   assign rsp1_result = rsp_result_q[1];
   assign rsp0_zero   = rsp_zero_q[0];
   assign rsp1_zero   = rsp_zero_q[1];
   assign op_count    = op_count_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  operation of requester N accepted this cycle when valid&ready.
REQ-006 reqN_srca, reqN_srcb  input  32  operands for requester N.
REQ-007 reqN_ctrl  input  3  ALUControl code for requester N, passed unmodified to the ALU.
REQ-008 rspN_valid  output  1  result for requester N held.
REQ-009 rspN_ready  input  1  requester N consumes result when rspN_valid&rspN_ready.
REQ-010 rspN_result  output  32  ALUResult of requester N's operation.
REQ-011 rspN_zero  output  1  Zero flag of that operation.
REQ-012 op_count  output  CNT_W  number of results delivered into response registers.

Function
REQ-013 One shared ALU; at most one operation accepted per cycle across both requesters.
REQ-014 pendN = (stage_valid & stage_owner==N) | (rspN_valid & ~rspN_ready); one outstanding op per requester.
REQ-015 eligibleN = reqN_valid & ~pendN.
REQ-016 Only one eligible: grant it. Both eligible: grant requester indicated by rr_ptr.
REQ-017 reqN_ready = grantN; ready is asserted only for a granted, eligible requester (no combinational dependence of reqN_ready on anything but state, reqN_valid and rspN_ready).
REQ-018 rr_ptr updates only on a grant: rr_ptr <= ~granted index; unchanged when no grant.
REQ-019 On accept: stage register loads srca, srcb, ctrl, owner; stage_valid <= 1 next edge.
REQ-020 No accept in a cycle: stage_valid <= 0 next edge.
REQ-021 ALU operands driven only from stage register; ALU is purely combinational.
REQ-022 stage_valid with owner N: rspN_result/rspN_zero load ALU outputs, rspN_valid <= 1 at next edge.
REQ-023 Latency: accept in cycle t -> rspN_valid high in cycle t+2; throughput one op/cycle overall, one op per 2 cycles per requester minimum.
REQ-024 rspN_valid clears at edge when rspN_valid & rspN_ready and no new load for N; a load in the same edge has priority (valid stays 1, data updates).
REQ-025 rspN_result/rspN_zero hold stable while rspN_valid & ~rspN_ready.
REQ-026 op_count increments by 1 on each response-register load; wraps 2^CNT_W-1 -> 0.
REQ-027 reqN_* inputs ignored when not accepted; changing them while not ready has no effect.
REQ-028 Invariant: a response register is never overwritten while valid and not consumed.

Reset
REQ-029 reset asserted at edge: stage_valid=0, rsp0_valid=rsp1_valid=0, rr_ptr=0 (requester 0 favoured), op_count=0.
REQ-030 reset mid-operation discards staged and held results; no response appears for ops accepted before reset.
REQ-031 During reset cycle req0_ready=req1_ready=0; data registers need not be reset (outputs qualified by valid).

Structure
REQ-032 Shared package alu_arb_pkg: XLEN=32, ALUControl code constants (ADD=000, SUB=001, AND=010, OR=011, SLT=101), requester-index type.
REQ-033 Exactly one sub-module: the existing ALU (SrcA, SrcB, ALUControl, ALUResult, Zero), instantiated once.
REQ-034 Arbitration, stage and response registers kept in alu_arbiter; no further hierarchy.

Verification
REQ-035 req0 only: srca=10, srcb=20, ctrl=000 -> req0_ready same cycle, rsp0_valid two cycles later, result=30, zero=0, op_count=1.
REQ-036 Both valid from reset: req0 10-10 (001), req1 10 AND 20 (010) -> req0 granted first, req1 next cycle; rsp0 result=0 zero=1, rsp1 result=0 zero=1; rr_ptr alternates.
REQ-037 Both requesters continuously valid, rsp ready held 1, 20 cycles -> grants strictly alternate, 1 accept per cycle, each requester served every 2 cycles.
REQ-038 rsp1_ready=0 with rsp1 holding 10 OR 20=30 -> req1_ready stays 0, rsp1_result stays 30; req0 still served every 2 cycles; rsp1_ready=1 releases req1 next cycle.
REQ-039 Assert reset one cycle after accepting req0 (10 SLT 20) -> no rsp0_valid afterwards, op_count=0, rr_ptr=0.
REQ-040 Preload op_count to 2^CNT_W-1 via ops (CNT_W=4, 15 ops) -> 16th op wraps op_count to 0.
